multicycle_controller: RTL and testbench

Multi-cycle control unit for the MIPS-subset datapath; successor to the single-cycle controller. It sequences each instruction through fetch, decode, execute, memory and write-back states, so one shared memory and one ALU can serve the whole instruction. Memory accesses stall on a ready handshake, and opcode encodings are parameters. It also flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/memory/write-back
// over a shared memory and ALU, with ready-handshake stalls, illegal-opcode trap and retire counter.
module multicycle_controller #(
    parameter int             OPC_W    = 6,
    parameter logic [OPC_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OPC_W-1:0] OP_ADDI  = 6'b000001,
    parameter logic [OPC_W-1:0] OP_SLTI  = 6'b000010,
    parameter logic [OPC_W-1:0] OP_LW    = 6'b000011,
    parameter logic [OPC_W-1:0] OP_SW    = 6'b000100,
    parameter logic [OPC_W-1:0] OP_BEQ   = 6'b000101,
    parameter logic [OPC_W-1:0] OP_J     = 6'b000110,
    parameter logic [OPC_W-1:0] OP_JR    = 6'b000111,
    parameter logic [OPC_W-1:0] OP_JAL   = 6'b001000,
    parameter bit             WAIT_EN  = 1'b1,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opc,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EX_R     = 4'd2,
        EX_I     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JREG     = 4'd11,
        JLINK    = 4'd12,
        TRAP     = 4'd13
    } state_e;

    state_e           state_q, state_d;
    logic             active_q, active_d;
    logic             rtype_wb_q, rtype_wb_d;
    logic             store_q, store_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ready_s;
    logic             retire_s;

    assign ready_s = WAIT_EN ? mem_ready : 1'b1;

    // State and bookkeeping registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            active_q   <= 1'b0;
            rtype_wb_q <= 1'b0;
            store_q    <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            rtype_wb_q <= rtype_wb_d;
            store_q    <= store_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state logic; active_q holds off the first fetch until reset has been released for a cycle
    always_comb begin
        state_d    = state_q;
        active_d   = 1'b1;
        rtype_wb_d = rtype_wb_q;
        store_d    = store_q;
        retire_s   = 1'b0;
        case (state_q)
            FETCH: begin
                if (active_q && ready_s) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                store_d = (opc == OP_SW);
                if (opc == OP_RTYPE) begin
                    state_d = EX_R;
                end else if ((opc == OP_ADDI) || (opc == OP_SLTI)) begin
                    state_d = EX_I;
                end else if ((opc == OP_LW) || (opc == OP_SW)) begin
                    state_d = MEM_ADDR;
                end else if (opc == OP_BEQ) begin
                    state_d = BRANCH;
                end else if (opc == OP_J) begin
                    state_d = JUMP;
                end else if (opc == OP_JR) begin
                    state_d = JREG;
                end else if (opc == OP_JAL) begin
                    state_d = JLINK;
                end else begin
                    state_d = TRAP;
                end
            end
            EX_R: begin
                rtype_wb_d = 1'b1;
                state_d    = ALU_WB;
            end
            EX_I: begin
                rtype_wb_d = 1'b0;
                state_d    = ALU_WB;
            end
            MEM_ADDR: state_d = store_q ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (ready_s) begin
                    state_d = MEM_WB;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_WR: begin
                if (ready_s) begin
                    state_d  = FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = MEM_WR;
                end
            end
            ALU_WB, MEM_WB, BRANCH, JUMP, JREG, JLINK: begin
                state_d  = FETCH;
                retire_s = 1'b1;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == TRAP);
    assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire_s};

    // Output decode: Moore per state except pc_en/ir_write; everything is held at zero while in reset
    always_comb begin
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        retired    = '0;
        if (rst_n && active_q) begin
            instr_done = retire_s;
            illegal    = illegal_q;
            retired    = retired_q;
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = ready_s;
                    pc_en     = ready_s;
                end
                DECODE: alu_src_b = 2'b11;
                EX_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                EX_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opc == OP_SLTI) ? 2'b11 : 2'b00;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = rtype_wb_q ? 2'b01 : 2'b00;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                JREG: begin
                    pc_src = 2'b11;
                    pc_en  = 1'b1;
                end
                JLINK: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                end
                TRAP:    illegal = 1'b1;
                default: illegal = illegal_q;
            endcase
        end else begin
            retired = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (default build, WAIT_EN=0 build, CNT_W=2 build).
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // main instance
    logic        rst_n, zero, mem_ready;
    logic [5:0]  opc;
    logic        ir_write, i_or_d, mem_read, mem_write, pc_en, alu_src_a, reg_write, instr_done, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic [15:0] retired;
    logic [18:0] outs;
    assign outs = {ir_write, i_or_d, mem_read, mem_write, pc_en, pc_src, alu_src_a, alu_src_b,
                   alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal};

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    // WAIT_EN=0 instance
    logic        rst_n_nw, mr_nw;
    logic [5:0]  opc_nw;
    logic        ir_write_nw, i_or_d_nw, mem_read_nw, mem_write_nw, pc_en_nw, alu_src_a_nw;
    logic        reg_write_nw, instr_done_nw, illegal_nw;
    logic [1:0]  pc_src_nw, alu_src_b_nw, alu_op_nw, reg_dst_nw, mem_to_reg_nw;
    logic [15:0] retired_nw;

    multicycle_controller #(.WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n_nw), .opc(opc_nw), .zero(1'b0), .mem_ready(mr_nw),
        .ir_write(ir_write_nw), .i_or_d(i_or_d_nw), .mem_read(mem_read_nw), .mem_write(mem_write_nw),
        .pc_en(pc_en_nw), .pc_src(pc_src_nw), .alu_src_a(alu_src_a_nw), .alu_src_b(alu_src_b_nw),
        .alu_op(alu_op_nw), .reg_write(reg_write_nw), .reg_dst(reg_dst_nw), .mem_to_reg(mem_to_reg_nw),
        .instr_done(instr_done_nw), .illegal(illegal_nw), .retired(retired_nw)
    );

    // CNT_W=2 instance
    logic        rst_n_c2, mr_c2;
    logic [5:0]  opc_c2;
    logic        ir_write_c2, i_or_d_c2, mem_read_c2, mem_write_c2, pc_en_c2, alu_src_a_c2;
    logic        reg_write_c2, instr_done_c2, illegal_c2;
    logic [1:0]  pc_src_c2, alu_src_b_c2, alu_op_c2, reg_dst_c2, mem_to_reg_c2;
    logic [1:0]  retired_c2;

    multicycle_controller #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n_c2), .opc(opc_c2), .zero(1'b0), .mem_ready(mr_c2),
        .ir_write(ir_write_c2), .i_or_d(i_or_d_c2), .mem_read(mem_read_c2), .mem_write(mem_write_c2),
        .pc_en(pc_en_c2), .pc_src(pc_src_c2), .alu_src_a(alu_src_a_c2), .alu_src_b(alu_src_b_c2),
        .alu_op(alu_op_c2), .reg_write(reg_write_c2), .reg_dst(reg_dst_c2), .mem_to_reg(mem_to_reg_c2),
        .instr_done(instr_done_c2), .illegal(illegal_c2), .retired(retired_c2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction on the main instance; pat[c] is mem_ready in cycle c.
    task automatic run_main(input logic [5:0] op, input logic [63:0] pat, input logic z,
                            output int cyc, output int pe, output int mr);
        opc = op;
        zero = z;
        cyc = 0;
        pe = 0;
        mr = 0;
        for (int c = 1; c <= 40; c++) begin
            mem_ready = pat[c];
            #1;
            if (pc_en) pe++;
            if (mem_read) mr++;
            if (instr_done) begin
                cyc = c;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opc = 6'b000000; zero = 1'b1; mem_ready = 1'b1;
        step();
        step();
        checks++;
        if (outs !== 19'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_low outs=%b retired=%0d expected all 0", outs, retired);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early mem_read=%b expected 0", mem_read);
        end
        step();
    endtask

    task automatic test_rtype();
        opc = 6'b000000; mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_read, ir_write, pc_en, i_or_d, alu_src_a, alu_src_b, alu_op} !== 9'b111000100) begin
            failures++;
            $display("FAIL rtype_fetch got=%b expected 111000100",
                     {mem_read, ir_write, pc_en, i_or_d, alu_src_a, alu_src_b, alu_op});
        end
        step();
        checks++;
        if ({mem_read, alu_src_a, alu_src_b, alu_op} !== 6'b001100) begin
            failures++;
            $display("FAIL rtype_decode got=%b expected 001100", {mem_read, alu_src_a, alu_src_b, alu_op});
        end
        step();
        checks++;
        if ({alu_src_a, alu_src_b, alu_op, reg_write} !== 6'b100100) begin
            failures++;
            $display("FAIL rtype_ex got=%b expected 100100", {alu_src_a, alu_src_b, alu_op, reg_write});
        end
        step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 6'b101001) begin
            failures++;
            $display("FAIL rtype_wb got=%b expected 101001", {reg_write, reg_dst, mem_to_reg, instr_done});
        end
        step();
        checks++;
        if (retired !== 16'd1 || instr_done !== 1'b0 || mem_read !== 1'b1) begin
            failures++;
            $display("FAIL rtype_retire retired=%0d done=%b mem_read=%b expected 1 0 1",
                     retired, instr_done, mem_read);
        end
    endtask

    task automatic test_cycle_counts();
        logic [5:0] ops [9] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8};
        int         exp [9] = '{4, 4, 4, 4, 5, 3, 3, 3, 3};
        int cyc, pe, mr;
        for (int i = 0; i < 9; i++) begin
            run_main(ops[i], 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, cyc, pe, mr);
            checks++;
            if (cyc !== exp[i]) begin
                failures++;
                $display("FAIL cycles_op%0d got=%0d expected %0d", ops[i], cyc, exp[i]);
            end
        end
        checks++;
        if (retired !== 16'd10) begin
            failures++;
            $display("FAIL cycles_retired got=%0d expected 10", retired);
        end
    endtask

    task automatic test_lw_stall();
        logic [63:0] pat;
        int cyc, pe, mr;
        pat = 64'hFFFF_FFFF_FFFF_FFFF;
        pat[1] = 1'b0; pat[2] = 1'b0; pat[6] = 1'b0; pat[7] = 1'b0; pat[8] = 1'b0;
        run_main(6'd3, pat, 1'b0, cyc, pe, mr);
        checks++;
        if (cyc !== 10 || pe !== 1 || mr !== 7) begin
            failures++;
            $display("FAIL lw_stall cycles=%0d pc_en_pulses=%0d mem_read_cycles=%0d expected 10 1 7", cyc, pe, mr);
        end
        checks++;
        if (retired !== 16'd11) begin
            failures++;
            $display("FAIL lw_retired got=%0d expected 11", retired);
        end
    endtask

    task automatic test_beq();
        opc = 6'd5; mem_ready = 1'b1; zero = 1'b1;
        step();
        step();
        checks++;
        if ({pc_en, pc_src, alu_op, alu_src_a, alu_src_b, instr_done} !== 9'b101011001) begin
            failures++;
            $display("FAIL beq_taken got=%b expected 101011001",
                     {pc_en, pc_src, alu_op, alu_src_a, alu_src_b, instr_done});
        end
        step();
        zero = 1'b0;
        step();
        step();
        checks++;
        if ({pc_en, pc_src, instr_done} !== 4'b0011) begin
            failures++;
            $display("FAIL beq_not_taken got=%b expected 0011", {pc_en, pc_src, instr_done});
        end
        step();
        checks++;
        if (retired !== 16'd13) begin
            failures++;
            $display("FAIL beq_retired got=%0d expected 13", retired);
        end
    endtask

    task automatic test_jal();
        opc = 6'd8; mem_ready = 1'b1;
        step();
        step();
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, pc_en, pc_src, instr_done} !== 9'b110101101) begin
            failures++;
            $display("FAIL jal got=%b expected 110101101",
                     {reg_write, reg_dst, mem_to_reg, pc_en, pc_src, instr_done});
        end
        step();
    endtask

    task automatic test_trap();
        int bad;
        opc = 6'b111111; mem_ready = 1'b1;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (illegal !== 1'b1 || {ir_write, mem_read, mem_write, pc_en, reg_write, instr_done} !== 6'd0)
                bad++;
            step();
        end
        checks++;
        if (bad !== 0 || retired !== 16'd14) begin
            failures++;
            $display("FAIL trap_hold bad_cycles=%0d retired=%0d expected 0 14", bad, retired);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (outs !== 19'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL trap_reset outs=%b retired=%0d expected all 0", outs, retired);
        end
        rst_n = 1'b1;
        opc = 6'd0;
        step();
        checks++;
        if (mem_read !== 1'b1 || illegal !== 1'b0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL trap_resume mem_read=%b illegal=%b retired=%0d expected 1 0 0",
                     mem_read, illegal, retired);
        end
    endtask

    task automatic test_no_wait();
        int cyc;
        int wr;
        opc_nw = 6'd4; mr_nw = 1'b0;
        rst_n_nw = 1'b1;
        step();
        cyc = 0;
        wr = 0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_write_nw) wr++;
            if (instr_done_nw) begin
                cyc = c;
                break;
            end
            step();
        end
        checks++;
        if (cyc !== 4 || wr !== 1) begin
            failures++;
            $display("FAIL no_wait_sw cycles=%0d mem_write_cycles=%0d expected 4 1", cyc, wr);
        end
    endtask

    task automatic test_wrap();
        int done;
        opc_c2 = 6'd6; mr_c2 = 1'b1;
        rst_n_c2 = 1'b1;
        step();
        done = 0;
        for (int c = 0; c < 60 && done < 5; c++) begin
            if (instr_done_c2) done++;
            step();
        end
        checks++;
        if (done !== 5 || retired_c2 !== 2'd1) begin
            failures++;
            $display("FAIL wrap retires=%0d retired=%0d expected 5 1", done, retired_c2);
        end
    endtask

    initial begin
        rst_n_nw = 1'b0; opc_nw = 6'd0; mr_nw = 1'b0;
        rst_n_c2 = 1'b0; opc_c2 = 6'd0; mr_c2 = 1'b1;
        test_reset();
        test_rtype();
        test_cycle_counts();
        test_lw_stall();
        test_beq();
        test_jal();
        test_trap();
        test_no_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
